pkt_tx_ctrl_50: RTL and testbench
=================================

# pkt_tx_ctrl_50

Transmit-side packet controller for the 50 MHz serial byte link. It reads 4-byte payloads from a transmit FIFO. For each payload it sends one header byte (0xA5 or 0xC3) followed by the 4 data bytes. Each byte goes out MSB-first on `serial_data`, framed by `data_ena`, in the exact format the link's receive-side controller expects: a byte completes on the falling edge of `data_ena`, a header is a5/c3, and each header is followed by 4 data bytes.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: `data_ena`-low cycles after every byte. Legal range is 2..15.
- `CNT_W`, default 4: width of the FIFO occupancy input.

Ports:
- `clk_50`, input, 1: the single clock. All logic is on its rising edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `tx_en`, input, 1: enables the start of new packets.
- `hdr_sel`, input, 1: header select. 0 sends 0xA5, 1 sends 0xC3. Sampled at packet start.
- `fifo_cnt`, input, CNT_W: number of words held in the transmit FIFO.
- `fifo_rd_data`, input, 8: FIFO read data. Valid the cycle after `rd_fifo`.
- `rd_fifo`, output, 1: FIFO read strobe, a 1-cycle pulse.
- `data_ena`, output, 1: byte framing. High for exactly 8 cycles per byte.
- `serial_data`, output, 1: serial bit, MSB first. Valid while `data_ena` = 1.
- `busy`, output, 1: high from packet start through the last gap cycle.
- `pkt_done`, output, 1: 1-cycle pulse in the last gap cycle of a packet.

## Operation
- Registers:
  - state: IDLE / SHIFT / GAP.
  - 8-bit shift register `sreg`.
  - 3-bit bit counter.
  - gap counter.
  - 3-bit byte index: 0 = header, 1..4 = data.
- All outputs are registered.
- **IDLE:**
  - Starts a packet when `tx_en` = 1 and `fifo_cnt` >= 4.
  - On start, load `sreg` with the header (0xA5 or 0xC3 per `hdr_sel`), clear byte index, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:**
  - `data_ena` = 1 and `serial_data` = `sreg[7]`.
  - Shift `sreg` left once per cycle.
  - After the 8th bit, go to GAP.
- **GAP:**
  - `data_ena` = 0 and `serial_data` = 0 for `GAP_CYCLES` cycles.
  - If byte index < 4: pulse `rd_fifo` in the 1st gap cycle and load `sreg` from `fifo_rd_data` in the 2nd gap cycle.
  - At the end of the gap, increment byte index and return to SHIFT.
  - If byte index = 4: no read. Pulse `pkt_done` in the final gap cycle, then go to IDLE.
- Exactly 4 `rd_fifo` pulses per packet. There are none outside a packet.
- `tx_en` or `fifo_cnt` changing mid-packet has no effect: a started packet always completes.
- `hdr_sel` is ignored except in the IDLE start cycle.
- Reset (asserted at any time, including mid-packet):
  - State returns to IDLE.
  - All outputs go to 0: `rd_fifo`, `data_ena`, `serial_data`, `busy`, `pkt_done`.
  - The partial packet is abandoned, and FIFO words already read are discarded.
  - No bits are emitted until a fresh start after `reset_n` deasserts.

## Timing
- Start decision at cycle 0 (IDLE, conditions met).
- Header bit 7 appears in cycle 1, with `data_ena` = 1 and `busy` = 1.
- Header occupies cycles 1..8. Gap occupies cycles 9..8+G, where G = `GAP_CYCLES`.
- `rd_fifo` is high in cycle 9. `fifo_rd_data` is sampled in cycle 10.
- Byte k (k = 0..4) starts at cycle 1 + k·(8+G).
- Packet length is 5·(8+G) cycles: 50 cycles at G = 2.
- `pkt_done` and the last `busy` cycle fall in cycle 5·(8+G).
- Back-to-back packets:
  - IDLE lasts one cycle minimum.
  - The next packet's header starts no earlier than cycle 5·(8+G)+2.
  - The `data_ena` low time between packets is therefore G+1 cycles minimum.
- `data_ena` is never high for other than exactly 8 consecutive cycles.

## Test plan
- **Single packet:** G = 2, `hdr_sel` = 0, FIFO holds 0x12, 0x34, 0x56, 0x78, `tx_en` = 1.
  - Deserialized bytes are A5, 12, 34, 56, 78.
  - 4 `rd_fifo` pulses at cycles 9, 19, 29, 39.
  - `pkt_done` at cycle 50. `busy` then drops.
- **Header select:** `hdr_sel` = 1 at start, toggled to 0 mid-packet.
  - First byte is 0xC3. Payload is unchanged.
- **Insufficient data:** `fifo_cnt` = 3 held for 100 cycles.
  - `data_ena`, `rd_fifo` and `busy` stay 0.
  - Raising `fifo_cnt` to 4 starts a packet within 1 cycle.
- **Back-to-back:** 8 words queued, `tx_en` held high.
  - Two packets, 10 data bytes total, 8 reads.
  - Inter-packet `data_ena` low time is exactly 3 cycles at G = 2.
- **Reset mid-packet:** assert `reset_n` = 0 during data byte 2, bit 3.
  - All outputs are 0 asynchronously, before the next clock edge.
  - After release, the next packet begins with a full header and reads 4 new words.
- **Gap parameter:** G = 5, plus `tx_en` dropped mid-packet.
  - Packet completes.
  - Gaps are exactly 5 cycles.
  - `pkt_done` at cycle 65.
  - No new packet starts while `tx_en` = 0.

Source files
------------

// File: rtl/pkt_tx_ctrl_50.sv
// Transmit packet controller: pulls 4 payload bytes from a FIFO and serializes
// header + payload MSB-first, framed by data_ena with a fixed inter-byte gap.
module pkt_tx_ctrl_50 #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             tx_en,
  input  logic             hdr_sel,
  input  logic [CNT_W-1:0] fifo_cnt,
  input  logic [7:0]       fifo_rd_data,
  output logic             rd_fifo,
  output logic             data_ena,
  output logic             serial_data,
  output logic             busy,
  output logic             pkt_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] GAP_PRE   = 4'(GAP_CYCLES - 2);
  localparam logic [2:0] LAST_BYTE = 3'd4;

  state_t     state_q;
  logic [7:0] shiftReg_q;
  logic [2:0] bitCnt_q;
  logic [3:0] gapCnt_q;
  logic [2:0] byteIdx_q;
  logic       rdFifo_q;
  logic       dataEna_q;
  logic       serial_q;
  logic       busy_q;
  logic       pktDone_q;

  logic [7:0] headerByte;
  logic [7:0] nextByte;
  logic       startOk;

  // With the minimum gap the FIFO word arrives in the same cycle it must be
  // launched, so it bypasses the shift register in that case.
  always_comb begin
    headerByte = hdr_sel ? 8'hC3 : 8'hA5;
    nextByte   = (gapCnt_q == 4'd1) ? fifo_rd_data : shiftReg_q;
    startOk    = tx_en && (fifo_cnt >= CNT_W'(4));
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shiftReg_q <= 8'h00;
      bitCnt_q   <= 3'd0;
      gapCnt_q   <= 4'd0;
      byteIdx_q  <= 3'd0;
      rdFifo_q   <= 1'b0;
      dataEna_q  <= 1'b0;
      serial_q   <= 1'b0;
      busy_q     <= 1'b0;
      pktDone_q  <= 1'b0;
    end else begin
      rdFifo_q  <= 1'b0;
      pktDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startOk) begin
            state_q    <= SHIFT;
            dataEna_q  <= 1'b1;
            busy_q     <= 1'b1;
            serial_q   <= headerByte[7];
            shiftReg_q <= {headerByte[6:0], 1'b0};
            bitCnt_q   <= 3'd0;
            byteIdx_q  <= 3'd0;
          end
        end

        SHIFT: begin
          if (bitCnt_q == 3'd7) begin
            state_q   <= GAP;
            dataEna_q <= 1'b0;
            serial_q  <= 1'b0;
            gapCnt_q  <= 4'd0;
            rdFifo_q  <= (byteIdx_q != LAST_BYTE);
          end else begin
            serial_q   <= shiftReg_q[7];
            shiftReg_q <= {shiftReg_q[6:0], 1'b0};
            bitCnt_q   <= bitCnt_q + 3'd1;
          end
        end

        GAP: begin
          gapCnt_q <= gapCnt_q + 4'd1;
          if (gapCnt_q == 4'd1 && byteIdx_q != LAST_BYTE) begin
            shiftReg_q <= fifo_rd_data;
          end
          if (gapCnt_q == GAP_PRE && byteIdx_q == LAST_BYTE) begin
            pktDone_q <= 1'b1;
          end
          if (gapCnt_q == GAP_LAST) begin
            if (byteIdx_q == LAST_BYTE) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= SHIFT;
              dataEna_q  <= 1'b1;
              serial_q   <= nextByte[7];
              shiftReg_q <= {nextByte[6:0], 1'b0};
              bitCnt_q   <= 3'd0;
              byteIdx_q  <= byteIdx_q + 3'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_fifo     = rdFifo_q;
  assign data_ena    = dataEna_q;
  assign serial_data = serial_q;
  assign busy        = busy_q;
  assign pkt_done    = pktDone_q;

endmodule

// File: tb/tb_pkt_tx_ctrl_50.sv
// Bench for pkt_tx_ctrl_50: two instances (gap 2 and gap 5) fed by small FIFO
// models, checked cycle-by-cycle against an arithmetic packet-timing model.
module tb_pkt_tx_ctrl_50;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic       reset_n;
  logic       txEn;
  logic       hdrSel;
  logic [3:0] fifoCntA, fifoCntB;
  logic [7:0] fifoDataA = 8'h00;
  logic [7:0] fifoDataB = 8'h00;
  logic       rdA, enaA, serA, busyA, doneA;
  logic       rdB, enaB, serB, busyB, doneB;

  int errors = 0;
  int checks = 0;
  int cur    = 0;
  int rdSeen = 0;

  logic [7:0] memA [64];
  logic [7:0] memB [64];
  int wrPtrA = 0, rdPtrA = 0, wrPtrB = 0, rdPtrB = 0;
  logic [7:0] modelQ [$];
  logic [4:0] obsVec;

  pkt_tx_ctrl_50 #(.GAP_CYCLES(2), .CNT_W(4)) dutA (
    .clk_50(clk_50), .reset_n(reset_n), .tx_en(txEn), .hdr_sel(hdrSel),
    .fifo_cnt(fifoCntA), .fifo_rd_data(fifoDataA), .rd_fifo(rdA),
    .data_ena(enaA), .serial_data(serA), .busy(busyA), .pkt_done(doneA)
  );

  pkt_tx_ctrl_50 #(.GAP_CYCLES(5), .CNT_W(4)) dutB (
    .clk_50(clk_50), .reset_n(reset_n), .tx_en(txEn), .hdr_sel(hdrSel),
    .fifo_cnt(fifoCntB), .fifo_rd_data(fifoDataB), .rd_fifo(rdB),
    .data_ena(enaB), .serial_data(serB), .busy(busyB), .pkt_done(doneB)
  );

  // FIFO models: read data appears the cycle after the strobe
  always @(posedge clk_50) begin
    if (rdA) begin
      fifoDataA <= memA[rdPtrA % 64];
      rdPtrA    <= rdPtrA + 1;
    end
    if (rdB) begin
      fifoDataB <= memB[rdPtrB % 64];
      rdPtrB    <= rdPtrB + 1;
    end
  end

  always_comb begin
    fifoCntA = ((wrPtrA - rdPtrA) > 15) ? 4'd15 : 4'(wrPtrA - rdPtrA);
    fifoCntB = ((wrPtrB - rdPtrB) > 15) ? 4'd15 : 4'(wrPtrB - rdPtrB);
    obsVec   = (cur == 1) ? {enaB, serB, rdB, doneB, busyB}
                          : {enaA, serA, rdA, doneA, busyA};
  end

  task automatic pushWord(input logic [7:0] w);
    if (cur == 1) begin
      memB[wrPtrB % 64] = w;
      wrPtrB = wrPtrB + 1;
    end else begin
      memA[wrPtrA % 64] = w;
      wrPtrA = wrPtrA + 1;
    end
    modelQ.push_back(w);
  endtask

  // Called at the mid-point of cycle 0 with start conditions applied; checks
  // every cycle of the packet. Event cycles of 0 mean "never".
  task automatic runPacket(input int resetAt, input int hdrFlipAt, input int txDropAt);
    int g;
    int p;
    int k;
    int o;
    logic [7:0] bytes [5];
    logic [7:0] cur8;
    logic [4:0] expV;
    g = (cur == 1) ? 5 : 2;
    p = 8 + g;
    checks++;
    if (modelQ.size() < 4) begin
      errors++;
      $display("[TB] FAIL model_words got %0d need 4", modelQ.size());
      return;
    end
    bytes[0] = hdrSel ? 8'hC3 : 8'hA5;
    for (int i = 1; i < 5; i++) bytes[i] = modelQ[i-1];
    for (int t = 1; t <= 5 * p; t++) begin
      @(negedge clk_50);
      k = (t - 1) / p;
      o = (t - 1) % p;
      cur8 = bytes[k];
      expV[4] = (o < 8);
      expV[3] = (o < 8) ? cur8[7 - o] : 1'b0;
      expV[2] = (o == 8) && (k < 4);
      expV[1] = (t == 5 * p);
      expV[0] = 1'b1;
      checks++;
      if (obsVec !== expV) begin
        errors++;
        $display("[TB] FAIL pkt_cycle%0d ena/ser/rd/done/busy got %b expected %b", t, obsVec, expV);
      end
      if (obsVec[2] === 1'b1) rdSeen++;
      if (t == hdrFlipAt) hdrSel = ~hdrSel;
      if (t == txDropAt) txEn = 1'b0;
      if (t == resetAt) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (obsVec !== 5'b0) begin
          errors++;
          $display("[TB] FAIL async_reset outputs got %b expected 00000", obsVec);
        end
        for (int r = 0; r < 4; r++)
          if (9 + r * p <= t) void'(modelQ.pop_front());
        return;
      end
    end
    repeat (4) void'(modelQ.pop_front());
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    txEn    = 1'b0;
    hdrSel  = 1'b0;
    repeat (3) @(negedge clk_50);
    checks++;
    if ({obsVec, enaB, serB, rdB, doneB, busyB} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b expected 0", {obsVec, enaB, serB, rdB, doneB, busyB});
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk_50);
      checks++;
      if (obsVec !== 5'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle got %b expected 00000", obsVec);
      end
    end
  endtask

  task automatic test_single_packet();
    int rdBefore;
    rdBefore = rdSeen;
    pushWord(8'h12); pushWord(8'h34); pushWord(8'h56); pushWord(8'h78);
    hdrSel = 1'b0;
    txEn   = 1'b1;
    runPacket(0, 0, 0);
    txEn = 1'b0;
    @(negedge clk_50);
    checks++;
    if (obsVec !== 5'b0) begin
      errors++;
      $display("[TB] FAIL single_after_done got %b expected 00000", obsVec);
    end
    checks++;
    if (rdSeen - rdBefore != 4) begin
      errors++;
      $display("[TB] FAIL single_reads got %0d expected 4", rdSeen - rdBefore);
    end
  endtask

  task automatic test_header_select();
    repeat (4) pushWord(8'($urandom_range(0, 255)));
    hdrSel = 1'b1;
    txEn   = 1'b1;
    runPacket(0, 15, 0);
    txEn = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic test_insufficient_data();
    repeat (3) pushWord(8'($urandom_range(0, 255)));
    hdrSel = 1'($urandom_range(0, 1));
    txEn   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50);
      checks++;
      if (obsVec !== 5'b0) begin
        errors++;
        $display("[TB] FAIL starved_cycle%0d got %b expected 00000", i, obsVec);
      end
    end
    pushWord(8'($urandom_range(0, 255)));
    runPacket(0, 0, 0);
    txEn = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic test_back_to_back();
    int rdBefore;
    rdBefore = rdSeen;
    repeat (8) pushWord(8'($urandom_range(0, 255)));
    hdrSel = 1'($urandom_range(0, 1));
    txEn   = 1'b1;
    runPacket(0, 0, 0);
    @(negedge clk_50);
    checks++;
    if (obsVec !== 5'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_cycle got %b expected 00000", obsVec);
    end
    hdrSel = 1'($urandom_range(0, 1));
    runPacket(0, 0, 0);
    txEn = 1'b0;
    @(negedge clk_50);
    checks++;
    if (rdSeen - rdBefore != 8) begin
      errors++;
      $display("[TB] FAIL b2b_reads got %0d expected 8", rdSeen - rdBefore);
    end
  endtask

  task automatic test_reset_mid_packet();
    repeat (4) pushWord(8'($urandom_range(0, 255)));
    hdrSel = 1'b0;
    txEn   = 1'b1;
    runPacket(25, 0, 0);
    txEn = 1'b0;
    repeat (2) begin
      @(negedge clk_50);
      checks++;
      if (obsVec !== 5'b0) begin
        errors++;
        $display("[TB] FAIL held_reset got %b expected 00000", obsVec);
      end
    end
    reset_n = 1'b1;
    @(negedge clk_50);
    repeat (2) pushWord(8'($urandom_range(0, 255)));
    hdrSel = 1'($urandom_range(0, 1));
    txEn   = 1'b1;
    runPacket(0, 0, 0);
    txEn = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic test_gap_param();
    int rdBefore;
    cur = 1;
    rdBefore = rdSeen;
    repeat (8) pushWord(8'($urandom_range(0, 255)));
    hdrSel = 1'($urandom_range(0, 1));
    txEn   = 1'b1;
    runPacket(0, 0, 20);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_50);
      checks++;
      if (obsVec !== 5'b0) begin
        errors++;
        $display("[TB] FAIL gap5_no_restart_cycle%0d got %b expected 00000", i, obsVec);
      end
    end
    checks++;
    if (rdSeen - rdBefore != 4) begin
      errors++;
      $display("[TB] FAIL gap5_reads got %0d expected 4", rdSeen - rdBefore);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_header_select();
    test_insufficient_data();
    test_back_to_back();
    test_reset_mid_packet();
    test_gap_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
